aes_job_sequencer: RTL and testbench

- Upstream job feeder and result collector for the hardened AES-128 core (aes128_hardened_top).
- Accepts key/plaintext jobs on a ready/valid stream and buffers them in a small FIFO.
- Issues one core start per job, waits for the core's valid or fault alert, and retries on fault or timeout.
- Returns ciphertext with error status on a ready/valid output stream, in job order.

---
 rtl/aes_seq_pkg.sv | 24 ++
 rtl/aes_seq_fifo.sv | 58 +++++
 rtl/aes_job_sequencer.sv | 135 +++++++++++++
 tb/tb_aes_job_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types for the AES job sequencer: block width, FSM state, job record.
package aes_seq_pkg;

   localparam int AES_BLOCK_W = 128;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DRAIN,
      OUT
   } aes_seq_state_t;

   typedef struct packed {
      logic [AES_BLOCK_W-1:0] key;
      logic [AES_BLOCK_W-1:0] plain;
   } aes_job_t;

   // Occupancy needs one extra bit so a full FIFO is distinguishable from empty.
   function automatic int occ_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/aes_seq_fifo.sv
// Ring-buffer job FIFO; the head stays visible until popped so it can be re-issued.
module aes_seq_fifo
   import aes_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic                        pop,
   input  aes_job_t                    wdata,
   output aes_job_t                    head,
   output logic                        full,
   output logic                        empty,
   output logic [occ_width(DEPTH)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = occ_width(DEPTH);

   aes_job_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: the storage array is deliberately not reset; pointers and count
   // define validity, and leaving it out keeps the array mappable to RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/aes_job_sequencer.sv
// Feeds queued jobs to the AES core one at a time and returns results in order.
// Define AES_SEQ_RETRY_EN to re-issue faulted jobs up to MAX_RETRY times.
module aes_job_sequencer
   import aes_seq_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int MAX_RETRY   = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [AES_BLOCK_W-1:0]           in_key,
   input  logic [AES_BLOCK_W-1:0]           in_plain,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [AES_BLOCK_W-1:0]           out_data,
   output logic                             out_err,
   output logic [1:0]                       out_retries,
   output logic                             core_start,
   output logic [AES_BLOCK_W-1:0]           core_key,
   output logic [AES_BLOCK_W-1:0]           core_plaintext,
   input  logic [AES_BLOCK_W-1:0]           core_ciphertext,
   input  logic                             core_valid,
   input  logic                             core_busy,
   input  logic                             core_fault_alert,
   output logic [15:0]                      fault_cnt,
   output logic [occ_width(FIFO_DEPTH)-1:0] jobs_pending
);

   localparam int               TMO_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   aes_seq_state_t   state;
   aes_seq_state_t   state_nxt;
   aes_job_t         in_job;
   aes_job_t         head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             fault_evt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [1:0]       retry;

   assign in_job = '{key: in_key, plain: in_plain};

   aes_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid),
      .pop   (pop),
      .wdata (in_job),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (jobs_pending)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      fault_evt = 1'b0;
      pop       = 1'b0;
      case (state)
         IDLE:  if (!fifo_empty && !core_busy) state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            // A fault outranks a simultaneous valid: that result cannot be trusted.
            if (core_fault_alert || tmo_cnt == TMO_LAST) begin
               fault_evt = 1'b1;
`ifdef AES_SEQ_RETRY_EN
               state_nxt = (retry < 2'(MAX_RETRY)) ? DRAIN : OUT;
`else
               state_nxt = OUT;
`endif
            end else if (core_valid) begin
               state_nxt = OUT;
            end
         end
`ifdef AES_SEQ_RETRY_EN
         DRAIN: if (!core_busy) state_nxt = ISSUE;
`endif
         OUT: begin
            if (out_ready) begin
               pop       = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         tmo_cnt        <= '0;
         core_key       <= '0;
         core_plaintext <= '0;
         out_data       <= '0;
         out_err        <= 1'b0;
         fault_cnt      <= '0;
      end else begin
         state <= state_nxt;
         if (state == ISSUE)     tmo_cnt <= '0;
         else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
         // Latch the head on entry to ISSUE so the core sees it stable through WAIT.
         if (state_nxt == ISSUE && state != ISSUE) begin
            core_key       <= head.key;
            core_plaintext <= head.plain;
         end
         if (fault_evt && fault_cnt != 16'hFFFF) fault_cnt <= fault_cnt + 1'b1;
         if (state == WAIT && state_nxt == OUT) begin
            out_data <= fault_evt ? '0 : core_ciphertext;
            out_err  <= fault_evt;
         end
      end
   end

`ifdef AES_SEQ_RETRY_EN
   always_ff @(posedge clk) begin
      if (rst)                              retry <= '0;
      else if (pop)                         retry <= '0;
      else if (fault_evt && state_nxt == DRAIN) retry <= retry + 1'b1;
   end
`else
   assign retry = 2'b00;
`endif

   assign in_ready    = !fifo_full;
   assign out_valid   = (state == OUT);
   assign core_start  = (state == ISSUE);
   assign out_retries = (state == OUT) ? retry : 2'b00;

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Directed bench for aes_job_sequencer with a behavioural AES core responder.
// Expectations follow the build: AES_SEQ_RETRY_EN selects the retry variant.
module tb_aes_job_sequencer;

`ifdef AES_SEQ_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   typedef enum int {M_NORMAL, M_FAULT1, M_SILENT, M_BOTH} core_mode_t;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_key;
   logic [127:0] in_plain;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         out_err;
   logic [1:0]   out_retries;
   logic         core_start;
   logic [127:0] core_key;
   logic [127:0] core_plaintext;
   logic [127:0] core_ciphertext;
   logic         core_valid;
   logic         core_busy;
   logic         core_fault_alert;
   logic [15:0]  fault_cnt;
   logic [2:0]   jobs_pending;

   aes_job_sequencer #(.FIFO_DEPTH(4), .MAX_RETRY(2), .TIMEOUT_CYC(64)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_key           (in_key),
      .in_plain         (in_plain),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .out_err          (out_err),
      .out_retries      (out_retries),
      .core_start       (core_start),
      .core_key         (core_key),
      .core_plaintext   (core_plaintext),
      .core_ciphertext  (core_ciphertext),
      .core_valid       (core_valid),
      .core_busy        (core_busy),
      .core_fault_alert (core_fault_alert),
      .fault_cnt        (fault_cnt),
      .jobs_pending     (jobs_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Stand-in AES core: responds 3 cycles after start, behaviour chosen by core_mode.
   core_mode_t core_mode;
   logic       model_valid = 1'b0;
   logic       model_fault = 1'b0;
   logic       inject_valid;
   int         attempt_cnt = 0;
   int         busy_cnt = 0;
   int         start_time[$];

   assign core_valid       = model_valid | inject_valid;
   assign core_fault_alert = model_fault;

   function automatic logic [127:0] cipher_of(input logic [127:0] k, input logic [127:0] p);
      if (k == FIPS_K && p == FIPS_P) return FIPS_C;
      return k ^ p ^ 128'h5a5a_a5a5_0f0f_f0f0_1234_5678_9abc_def0;
   endfunction

   initial begin
      core_busy       = 1'b0;
      core_ciphertext = '0;
   end

   always @(negedge clk) begin
      model_valid = 1'b0;
      model_fault = 1'b0;
      if (out_valid) attempt_cnt = 0;
      if (core_start) begin
         start_time.push_back(cyc);
         attempt_cnt++;
         busy_cnt  = 3;
         core_busy = 1'b1;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) begin
            core_busy       = 1'b0;
            core_ciphertext = cipher_of(core_key, core_plaintext);
            case (core_mode)
               M_NORMAL: model_valid = 1'b1;
               M_FAULT1: begin
                  model_fault = (attempt_cnt == 1);
                  model_valid = (attempt_cnt != 1);
               end
               M_BOTH: begin
                  model_fault = (attempt_cnt == 1);
                  model_valid = 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic push_one(input logic [127:0] k, input logic [127:0] p);
      in_key   = k;
      in_plain = p;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, input int budget);
      int n = 0;
      while (out_valid !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, out_valid, 1'b1);
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   int               s0;
   int               n_acc;
   int               n;
   logic [127:0]     bp_key  [4];
   logic [127:0]     bp_plain[4];

   initial begin
      rst          = 1'b1;
      in_valid     = 1'b0;
      in_key       = '0;
      in_plain     = '0;
      out_ready    = 1'b0;
      inject_valid = 1'b0;
      core_mode    = M_NORMAL;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_in_ready",  in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_start",     core_start, 1'b0);
      check("rst_pending",   jobs_pending, 3'd0);
      check("rst_fault_cnt", fault_cnt, 16'd0);
      check("rst_out_data",  out_data, 128'd0);
      check("rst_core_key",  core_key, 128'd0);

      // FIPS-197 job, including start latency
      core_mode = M_NORMAL;
      s0 = start_time.size();
      push_one(FIPS_K, FIPS_P);
      check("t1_pending",     jobs_pending, 3'd1);
      check("t1_start_early", core_start, 1'b0);
      @(negedge clk);
      check("t1_start",       core_start, 1'b1);
      check("t1_core_key",    core_key, FIPS_K);
      check("t1_core_pt",     core_plaintext, FIPS_P);
      wait_out("t1_out_valid", 40);
      check("t1_data",    out_data, FIPS_C);
      check("t1_err",     out_err, 1'b0);
      check("t1_retries", out_retries, 2'd0);
      take_result();
      check("t1_starts",  start_time.size() - s0, 1);
      check("t1_popped",  jobs_pending, 3'd0);
      check("t1_ov_drop", out_valid, 1'b0);

      // Fault on first attempt, valid on second
      do_reset();
      core_mode = M_FAULT1;
      s0 = start_time.size();
      push_one(128'h11, 128'h22);
      wait_out("t2_out_valid", 100);
      check("t2_err",       out_err, !RETRY_EN);
      check("t2_data",      out_data, RETRY_EN ? cipher_of(128'h11, 128'h22) : 128'd0);
      check("t2_retries",   out_retries, RETRY_EN ? 2'd1 : 2'd0);
      check("t2_fault_cnt", fault_cnt, 16'd1);
      take_result();
      check("t2_starts",    start_time.size() - s0, RETRY_EN ? 2 : 1);

      // Silent core: timeout on every attempt
      do_reset();
      core_mode = M_SILENT;
      s0 = start_time.size();
      push_one(128'h33, 128'h44);
      wait_out("t3_out_valid", 400);
      check("t3_err",       out_err, 1'b1);
      check("t3_data",      out_data, 128'd0);
      check("t3_retries",   out_retries, RETRY_EN ? 2'd2 : 2'd0);
      check("t3_fault_cnt", fault_cnt, RETRY_EN ? 16'd3 : 16'd1);
      check("t3_starts",    start_time.size() - s0, RETRY_EN ? 3 : 1);
      for (int i = s0 + 1; i < start_time.size(); i++)
         check("t3_gap", (start_time[i] - start_time[i-1]) >= 64, 1'b1);
      take_result();

      // Backpressure: five offers with out_ready low, only four fit
      do_reset();
      core_mode = M_NORMAL;
      s0 = start_time.size();
      n_acc = 0;
      for (int i = 0; i < 5; i++) begin
         in_key   = {4{32'h1000 + 32'(i)}};
         in_plain = {4{32'h2000 + 32'(i)}};
         if (i < 4) begin
            bp_key[i]   = in_key;
            bp_plain[i] = in_plain;
         end
         in_valid = 1'b1;
         if (in_ready) n_acc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("t4_accepted", n_acc, 4);
      check("t4_in_ready", in_ready, 1'b0);
      check("t4_pending",  jobs_pending, 3'd4);
      repeat (10) @(negedge clk);
      check("t4_hold_data", out_data, cipher_of(bp_key[0], bp_plain[0]));
      for (int j = 0; j < 4; j++) begin
         wait_out("t4_out_valid", 40);
         check("t4_data", out_data, cipher_of(bp_key[j], bp_plain[j]));
         check("t4_err",  out_err, 1'b0);
         take_result();
      end
      check("t4_starts",  start_time.size() - s0, 4);
      check("t4_drained", jobs_pending, 3'd0);

      // Same-cycle valid and fault is treated as a fault
      do_reset();
      core_mode = M_BOTH;
      s0 = start_time.size();
      push_one(128'h55, 128'h66);
      wait_out("t5_out_valid", 100);
      check("t5_fault_cnt", fault_cnt, 16'd1);
      check("t5_err",       out_err, !RETRY_EN);
      check("t5_retries",   out_retries, RETRY_EN ? 2'd1 : 2'd0);
      check("t5_data",      out_data, RETRY_EN ? cipher_of(128'h55, 128'h66) : 128'd0);
      take_result();
      check("t5_starts",    start_time.size() - s0, RETRY_EN ? 2 : 1);

      // Reset during WAIT, then a stale core_valid
      do_reset();
      core_mode = M_SILENT;
      push_one(128'h77, 128'h88);
      n = 0;
      while (core_start !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6_started", core_start, 1'b1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      inject_valid = 1'b1;
      @(negedge clk);
      inject_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("t6_no_out", out_valid, 1'b0);
         @(negedge clk);
      end
      check("t6_pending",   jobs_pending, 3'd0);
      check("t6_start",     core_start, 1'b0);
      check("t6_in_ready",  in_ready, 1'b1);
      check("t6_out_data",  out_data, 128'd0);
      check("t6_out_err",   out_err, 1'b0);
      check("t6_retries",   out_retries, 2'd0);
      check("t6_fault_cnt", fault_cnt, 16'd0);
      check("t6_core_key",  core_key, 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
